// File: rtl/stream_controller_if.sv
// stream_controller_if: FIFO / transmitter handshake bundle for the stream sequencer.
// master = sequencer side (drives strobes and validity),
// slave  = FIFO / transmitter side (drives occupancy, flags and sample requests).
interface stream_controller_if #(
    parameter int LEVEL_W = 5
);
    logic [LEVEL_W-1:0] fifo_level;
    logic               fifo_full;
    logic               fifo_empty;
    logic               tx_req;
    logic               write_en;
    logic               read_en;
    logic               fifo_flush;
    logic               validity;

    modport master (
        input  fifo_level,
        input  fifo_full,
        input  fifo_empty,
        input  tx_req,
        output write_en,
        output read_en,
        output fifo_flush,
        output validity
    );

    modport slave (
        output fifo_level,
        output fifo_full,
        output fifo_empty,
        output tx_req,
        input  write_en,
        input  read_en,
        input  fifo_flush,
        input  validity
    );
endinterface

// File: rtl/stream_controller.sv
// stream_controller: brings the I2S-to-S/PDIF stream up after PLL lock, aligns to the
// frame clock, pre-fills the sample FIFO, then paces FIFO writes (frame-clock edges)
// and reads (transmitter requests), re-priming on underrun. Drives active-low LEDs.
// Optional feature: define STREAM_CTRL_COUNTERS_EN to build the saturating
// overrun/underrun counters; otherwise both counter outputs are tied to 0.
module stream_controller #(
    parameter int LEVEL_W     = 5,
    parameter int PRIME_LEVEL = 8,
    parameter int LOCK_WAIT   = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_lock,
    input  logic                pin_i2s_fclk,
    stream_controller_if.master bus,
    output logic [1:0]          state,
    output logic [7:0]          overrun_cnt,
    output logic [7:0]          underrun_cnt,
    output logic                red,
    output logic                green,
    output logic                blue
);

    typedef enum logic [1:0] {
        LOCK  = 2'd0,
        SYNC  = 2'd1,
        PRIME = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam int LOCK_CNT_W = $clog2(LOCK_WAIT + 1);
    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_WAIT - 1);
    localparam logic [LEVEL_W-1:0]    PRIME_THR = LEVEL_W'(PRIME_LEVEL);

    state_t                cur;
    logic [LOCK_CNT_W-1:0] lock_cnt;
    logic                  lock_m, lock_s;
    logic                  fclk_m, fclk_s, fclk_prev, fclk_rise;
    logic                  write_en, read_en, fifo_flush, validity;
    logic                  write_evt;

    // {red, green, blue}, active low: exactly one lamp lit per state
    function automatic logic [2:0] leds_for(input state_t s);
        case (s)
            LOCK:    return 3'b011;
            RUN:     return 3'b101;
            default: return 3'b110;
        endcase
    endfunction

    // Two-stage synchronizers for lock and frame clock, plus registered fclk rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            fclk_m    <= 1'b0;
            fclk_s    <= 1'b0;
            fclk_prev <= 1'b0;
            fclk_rise <= 1'b0;
        end else begin
            lock_m    <= pll_lock;
            lock_s    <= lock_m;
            fclk_m    <= pin_i2s_fclk;
            fclk_s    <= fclk_m;
            fclk_prev <= fclk_s;
            fclk_rise <= fclk_s & ~fclk_prev;
        end
    end

    // A frame edge only counts once the stream has left LOCK and lock is still held
    assign write_evt = lock_s && fclk_rise && (cur != LOCK);

    // Sequencer FSM with all strobes, validity and LEDs registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur                <= LOCK;
            lock_cnt           <= '0;
            write_en           <= 1'b0;
            read_en            <= 1'b0;
            fifo_flush         <= 1'b0;
            validity           <= 1'b0;
            {red, green, blue} <= leds_for(LOCK);
        end else begin
            write_en   <= 1'b0;
            read_en    <= 1'b0;
            fifo_flush <= 1'b0;
            if (!lock_s) begin
                // lock loss overrides everything, including pending strobes
                cur                <= LOCK;
                lock_cnt           <= '0;
                validity           <= 1'b0;
                {red, green, blue} <= leds_for(LOCK);
            end else begin
                if (write_evt && !bus.fifo_full)
                    write_en <= 1'b1;
                case (cur)
                    LOCK: begin
                        if (lock_cnt == LOCK_LAST) begin
                            cur                <= SYNC;
                            lock_cnt           <= '0;
                            fifo_flush         <= 1'b1;
                            {red, green, blue} <= leds_for(SYNC);
                        end else begin
                            lock_cnt <= lock_cnt + LOCK_CNT_W'(1);
                        end
                    end
                    SYNC: begin
                        if (fclk_rise) begin
                            cur                <= PRIME;
                            {red, green, blue} <= leds_for(PRIME);
                        end
                    end
                    PRIME: begin
                        if (bus.fifo_level >= PRIME_THR) begin
                            cur                <= RUN;
                            validity           <= 1'b1;
                            {red, green, blue} <= leds_for(RUN);
                        end
                    end
                    RUN: begin
                        if (bus.tx_req) begin
                            if (!bus.fifo_empty) begin
                                read_en <= 1'b1;
                            end else begin
                                // starved: mute and re-prime without flushing
                                cur                <= PRIME;
                                validity           <= 1'b0;
                                {red, green, blue} <= leds_for(PRIME);
                            end
                        end
                    end
                    default: begin
                        cur                <= LOCK;
                        validity           <= 1'b0;
                        {red, green, blue} <= leds_for(LOCK);
                    end
                endcase
            end
        end
    end

`ifdef STREAM_CTRL_COUNTERS_EN
    logic overrun_evt, underrun_evt;

    assign overrun_evt  = write_evt && bus.fifo_full;
    assign underrun_evt = lock_s && (cur == RUN) && bus.tx_req && bus.fifo_empty;

    // Saturating event counters; only rst clears them, lock loss does not
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_cnt  <= 8'd0;
            underrun_cnt <= 8'd0;
        end else begin
            if (overrun_evt && (overrun_cnt != 8'hFF))
                overrun_cnt <= overrun_cnt + 8'd1;
            if (underrun_evt && (underrun_cnt != 8'hFF))
                underrun_cnt <= underrun_cnt + 8'd1;
        end
    end
`else
    assign overrun_cnt  = 8'd0;
    assign underrun_cnt = 8'd0;
`endif

    assign state          = cur;
    assign bus.write_en   = write_en;
    assign bus.read_en    = read_en;
    assign bus.fifo_flush = fifo_flush;
    assign bus.validity   = validity;

endmodule

// File: tb/tb_stream_controller.sv
// tb_stream_controller: randomized + directed bench for stream_controller with a
// behavioural sequencer model and a simple FIFO occupancy environment.
module tb_stream_controller;
    localparam int LEVEL_W     = 5;
    localparam int PRIME_LEVEL = 8;
    localparam int LOCK_WAIT   = 16;
    localparam int DEPTH       = 20;
`ifdef STREAM_CTRL_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       fclk;
    logic [1:0] state;
    logic [7:0] overrun_cnt;
    logic [7:0] underrun_cnt;
    logic       red, green, blue;

    stream_controller_if #(.LEVEL_W(LEVEL_W)) bus ();

    stream_controller #(
        .LEVEL_W    (LEVEL_W),
        .PRIME_LEVEL(PRIME_LEVEL),
        .LOCK_WAIT  (LOCK_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .pin_i2s_fclk(fclk),
        .bus         (bus.master),
        .state       (state),
        .overrun_cnt (overrun_cnt),
        .underrun_cnt(underrun_cnt),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // environment
    int level      = 0;
    bit force_full = 1'b0;
    bit drive_tx   = 1'b0;
    bit fclk_on    = 1'b0;
    int fclk_half  = 4;
    int fclk_ph    = 0;

    // reference model: input history per clock edge since reset, plus sequencer state
    bit lock_h [0:8191];
    bit fclk_h [0:8191];
    int n_edge = 0;
    int m_state, m_run, m_ov, m_un;
    bit m_we, m_re, m_fl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_edge  = 0;
        m_state = 0;
        m_run   = 0;
        m_ov    = 0;
        m_un    = 0;
        m_we    = 1'b0;
        m_re    = 1'b0;
        m_fl    = 1'b0;
    endtask

    // One clock edge of the sequencer rules: lock seen 2 edges late, fclk edge 3 edges late
    task automatic model_edge();
        bit lk, rise;
        lock_h[n_edge] = pll_lock;
        fclk_h[n_edge] = fclk;
        lk   = (n_edge >= 2) ? lock_h[n_edge-2] : 1'b0;
        rise = (n_edge >= 3) && fclk_h[n_edge-3] && !((n_edge >= 4) && fclk_h[n_edge-4]);
        m_we = 1'b0;
        m_re = 1'b0;
        m_fl = 1'b0;
        if (!lk) begin
            m_state = 0;
            m_run   = 0;
        end else begin
            if (m_state != 0 && rise) begin
                if (bus.fifo_full) m_ov = (m_ov < 255) ? m_ov + 1 : 255;
                else               m_we = 1'b1;
            end
            case (m_state)
                0: begin
                    m_run++;
                    if (m_run == LOCK_WAIT) begin
                        m_state = 1;
                        m_fl    = 1'b1;
                        m_run   = 0;
                    end
                end
                1: if (rise) m_state = 2;
                2: if (int'(bus.fifo_level) >= PRIME_LEVEL) m_state = 3;
                3: if (bus.tx_req) begin
                    if (!bus.fifo_empty) m_re = 1'b1;
                    else begin
                        m_un    = (m_un < 255) ? m_un + 1 : 255;
                        m_state = 2;
                    end
                end
                default: ;
            endcase
        end
        if (n_edge < 8191) n_edge++;
    endtask

    function automatic logic [24:0] exp_vec();
        logic [7:0] ov;
        logic [7:0] un;
        ov = CNT_EN ? 8'(m_ov) : 8'd0;
        un = CNT_EN ? 8'(m_un) : 8'd0;
        return {2'(m_state), m_we, m_re, m_fl, (m_state == 3),
                (m_state != 0), (m_state != 3), !(m_state == 1 || m_state == 2), ov, un};
    endfunction

    function automatic logic [24:0] dut_vec();
        return {state, bus.write_en, bus.read_en, bus.fifo_flush, bus.validity,
                red, green, blue, overrun_cnt, underrun_cnt};
    endfunction

    // one clock: drive inputs, step model at the edge, compare at the falling edge, update FIFO
    task automatic cycle();
        if (fclk_on) begin
            fclk_ph++;
            if (fclk_ph >= fclk_half) begin
                fclk_ph = 0;
                fclk    = ~fclk;
            end
        end
        bus.tx_req     = drive_tx;
        drive_tx       = 1'b0;
        bus.fifo_level = LEVEL_W'(level);
        bus.fifo_full  = force_full || (level >= DEPTH);
        bus.fifo_empty = (level == 0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("cyc", 32'(dut_vec()), 32'(exp_vec()));
        if (bus.fifo_flush) level = 0;
        else begin
            if (bus.write_en && level < DEPTH) level++;
            if (bus.read_en && level > 0) level--;
        end
    endtask

    task automatic wait_state(input logic [1:0] tgt, input int lim, input string tag);
        int k = 0;
        while (state != tgt && k < lim) begin
            cycle();
            k++;
        end
        check(tag, 32'(state), 32'(tgt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int low;
        rst            = 1'b1;
        pll_lock       = 1'b1;
        fclk           = 1'b0;
        bus.tx_req     = 1'b0;
        bus.fifo_level = '0;
        bus.fifo_full  = 1'b0;
        bus.fifo_empty = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_leds", 32'({red, green, blue}), 32'h3);
        check("rst_strobes", 32'({bus.write_en, bus.read_en, bus.fifo_flush, bus.validity}), 32'd0);
        check("rst_cnt", 32'({overrun_cnt, underrun_cnt}), 32'd0);
        rst = 1'b0;

        // startup: LOCK_WAIT+2 cycles in LOCK, one flush on entering SYNC, then prime to RUN
        fclk_on = 1'b1;
        k = 0;
        while (state != 2'd1 && k < 100) begin
            cycle();
            k++;
        end
        check("sync_at", 32'(k), 32'(LOCK_WAIT + 2));
        check("flush_pulse", 32'(bus.fifo_flush), 32'd1);
        wait_state(2'd2, 100, "prime_up");
        wait_state(2'd3, 300, "run_up");
        check("run_green", 32'(green), 32'd0);
        check("run_valid", 32'(bus.validity), 32'd1);

        // write edge and tx_req sampled on the same cycle
        fclk_on = 1'b0;
        fclk    = 1'b0;
        repeat (6) cycle();
        fclk = 1'b1;
        repeat (3) cycle();
        drive_tx = 1'b1;
        cycle();
        check("sim_we", 32'(bus.write_en), 32'd1);
        check("sim_re", 32'(bus.read_en), 32'd1);
        fclk = 1'b0;
        repeat (3) cycle();

        // lock loss in RUN with a request arriving as loss is recognised
        pll_lock = 1'b0;
        cycle();
        cycle();
        drive_tx = 1'b1;
        cycle();
        check("ll_state", 32'(state), 32'd0);
        check("ll_re", 32'(bus.read_en), 32'd0);
        check("ll_we", 32'(bus.write_en), 32'd0);
        check("ll_red", 32'(red), 32'd0);
        pll_lock = 1'b1;
        fclk_on  = 1'b1;
        wait_state(2'd3, 400, "relock_run");

        // randomized traffic: requests, frame rate changes, forced full, short lock drops
        low = 0;
        for (int i = 0; i < 3000; i++) begin
            drive_tx = ($urandom_range(0, 5) == 0);
            if (low > 0) begin
                low--;
                if (low == 0) pll_lock = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                pll_lock = 1'b0;
                low      = $urandom_range(1, 4);
            end
            if ($urandom_range(0, 149) == 0) force_full = ~force_full;
            if ($urandom_range(0, 99) == 0) fclk_half = $urandom_range(2, 6);
            cycle();
        end
        pll_lock   = 1'b1;
        force_full = 1'b0;
        fclk_half  = 2;

        // overrun: 300 edges against a full FIFO saturate the counter, state holds RUN
        wait_state(2'd3, 400, "ov_run");
        force_full = 1'b1;
        repeat (1210) cycle();
        check("ov_state", 32'(state), 32'd3);
        check("ov_sat", 32'(overrun_cnt), CNT_EN ? 32'd255 : 32'd0);

        // underrun: drain to empty with frames stopped, then one more request
        force_full = 1'b0;
        fclk_on    = 1'b0;
        fclk       = 1'b0;
        repeat (6) cycle();
        check("pre_under", 32'(state), 32'd3);
        for (int i = 0; i < 40; i++) begin
            if (level == 0) break;
            drive_tx = 1'b1;
            cycle();
            cycle();
        end
        repeat (2) cycle();
        drive_tx = 1'b1;
        cycle();
        check("un_state", 32'(state), 32'd2);
        check("un_valid", 32'(bus.validity), 32'd0);
        check("un_re", 32'(bus.read_en), 32'd0);

        // asynchronous reset mid-operation
        fclk_on = 1'b1;
        repeat (20) cycle();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst", 32'(dut_vec()), 32'(exp_vec()));
        @(negedge clk);
        rst   = 1'b0;
        level = 0;
        model_reset();
        repeat (60) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
